// File: rtl/serializer_ctrl_if.sv
// serializer_ctrl_if: parallel-word input and serial-bit output handshakes
interface serializer_ctrl_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_out;
    modport master (input in_valid, in_data, ser_ready, output in_ready, ser_valid, ser_out);
    modport slave  (output in_valid, in_data, ser_ready, input in_ready, ser_valid, ser_out);
endinterface

// File: rtl/serializer_ctrl.sv
// serializer_ctrl: load/shift serializer sequencer with frame strobes and inter-frame gap
module serializer_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    serializer_ctrl_if.master        bus,
    output logic                     load_shift,
    output logic                     frame_start,
    output logic                     frame_end,
    output logic                     busy,
    output logic [7:0]               words_sent
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [3:0]       gap_cnt, gap_nx;
    logic [7:0]       words_nx;
    logic             accept, beat, last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            gap_cnt    <= '0;
            words_sent <= '0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            cnt        <= cnt_nx;
            gap_cnt    <= gap_nx;
            words_sent <= words_nx;
        end
    end

    always_comb begin
        last          = cnt == LAST;
        bus.ser_valid = state == SHIFT;
        bus.ser_out   = state == SHIFT ? (MSB_FIRST != 0 ? shreg[WIDTH-1] : shreg[0]) : 1'b0;
        // with no gap the next word is taken on the same edge as the last beat
        bus.in_ready  = state == IDLE || (GAP_CYCLES == 0 && state == SHIFT && last && bus.ser_ready);
        accept        = bus.in_valid && bus.in_ready;
        beat          = bus.ser_valid && bus.ser_ready;
        load_shift    = state != SHIFT;
        frame_start   = bus.ser_valid && cnt == '0;
        frame_end     = bus.ser_valid && last;
        busy          = state != IDLE;
        state_nx      = state;
        shreg_nx      = shreg;
        cnt_nx        = cnt;
        gap_nx        = gap_cnt;
        words_nx      = words_sent;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nx = bus.in_data;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    shreg_nx = MSB_FIRST != 0 ? shreg << 1 : shreg >> 1;
                    cnt_nx   = last ? '0 : cnt + 1'b1;
                    if (last) begin
                        words_nx = words_sent + 8'd1;
                        if (GAP_CYCLES > 0) begin
                            gap_nx   = GAP_INIT;
                            state_nx = GAP;
                        end else if (accept) begin
                            shreg_nx = bus.in_data;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                gap_nx   = gap_cnt == 4'd0 ? 4'd0 : gap_cnt - 4'd1;
                state_nx = gap_cnt == 4'd0 ? IDLE : GAP;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serializer_ctrl.sv
// tb_serializer_ctrl: vector table, corner sequences and randomized scoreboard for three configurations
module tb_serializer_ctrl;
    logic clk = 0;
    logic rst = 0;
    logic [2:0] iv = '0, sr = '0;
    logic [2:0] sv, so, fs, fe, ir, ls, by;
    logic [3:0] d [3];
    logic [7:0] ws [3];
    int n_cmp = 0, n_err = 0;

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       sr;
        logic [6:0] e;
        logic [7:0] w;
    } vec_t;
    vec_t tv [$];

    logic [3:0] pend [3];
    int         left [3], gap [3];
    logic [7:0] wcnt [3];
    logic       e_sv, e_ir;
    logic [6:0] e;
    logic [7:0] pat;

    always #5 clk = ~clk;

    // dut 0: gap 1, msb first; dut 1: gap 0, msb first; dut 2: gap 2, lsb first
    for (genvar g = 0; g < 3; g++) begin : u
        serializer_ctrl_if #(.WIDTH(4)) bus ();
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = d[g];
        assign bus.ser_ready = sr[g];
        assign sv[g] = bus.ser_valid;
        assign so[g] = bus.ser_out;
        assign ir[g] = bus.in_ready;
        serializer_ctrl #(.WIDTH(4), .GAP_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 2), .MSB_FIRST(g == 2 ? 0 : 1)) dut (
            .clk(clk), .rst(rst), .bus(bus),
            .load_shift(ls[g]), .frame_start(fs[g]), .frame_end(fe[g]),
            .busy(by[g]), .words_sent(ws[g])
        );
    end

    function automatic int gapof(input int i);
        return i == 0 ? 1 : i == 1 ? 0 : 2;
    endfunction

    function automatic logic [3:0] order(input int i, input logic [3:0] x);
        return i == 2 ? x : {x[0], x[1], x[2], x[3]};
    endfunction

    function automatic logic [6:0] st(input int i);
        return {sv[i], so[i], fs[i], fe[i], ir[i], ls[i], by[i]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        iv = '0;
        sr = '0;
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = '0;
            left[i] = 0;
            gap[i] = 0;
            wcnt[i] = '0;
        end
    endtask

    task automatic add(input logic v, input logic [3:0] dd, input logic r, input logic [6:0] ee, input logic [7:0] w);
        vec_t t;
        t.iv = v; t.d = dd; t.sr = r; t.e = ee; t.w = w;
        tv.push_back(t);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) d[i] = '0;
        // status bits: {ser_valid, ser_out, frame_start, frame_end, in_ready, load_shift, busy}
        add(1, 4'hB, 1, 7'b0000110, 0);
        add(0, 4'h0, 1, 7'b1110001, 0);
        add(0, 4'h0, 1, 7'b1000001, 0);
        add(0, 4'h0, 1, 7'b1100001, 0);
        add(0, 4'h0, 1, 7'b1101001, 0);
        add(0, 4'h0, 1, 7'b0000011, 1);
        add(1, 4'h6, 1, 7'b0000110, 1);
        add(0, 4'h0, 1, 7'b1010001, 1);
        add(0, 4'h0, 1, 7'b1100001, 1);
        add(1, 4'hF, 0, 7'b1100001, 1);
        add(1, 4'hF, 0, 7'b1100001, 1);
        add(1, 4'hF, 0, 7'b1100001, 1);
        add(0, 4'h0, 1, 7'b1100001, 1);
        add(0, 4'h0, 1, 7'b1001001, 1);
        add(0, 4'h0, 1, 7'b0000011, 2);
        add(0, 4'h0, 1, 7'b0000110, 2);

        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_status[%0d]", i), st(i), 7'b0000110);
            chk($sformatf("reset_words[%0d]", i), ws[i], 0);
        end

        // reset in the middle of a frame discards it
        step();
        iv[0] = 1; d[0] = 4'b1011; sr[0] = 1;
        step();
        iv[0] = 0;
        step();
        step();
        @(negedge clk);
        chk("mid_frame_before_rst", st(0), 7'b1100001);
        iv[0] = 1;
        rst = 1;
        step();
        rst = 0;
        iv[0] = 0;
        @(negedge clk);
        chk("mid_rst_status", st(0), 7'b0000110);
        chk("mid_rst_words", ws[0], 0);
        iv[0] = 1; d[0] = 4'b0110;
        step();
        iv[0] = 0;
        @(negedge clk);
        chk("post_rst_first_bit", st(0), 7'b1010001);

        do_reset();
        for (int r = 0; r < tv.size(); r++) begin
            iv[0] = tv[r].iv; d[0] = tv[r].d; sr[0] = tv[r].sr;
            @(negedge clk);
            chk($sformatf("tbl_status[%0d]", r), st(0), tv[r].e);
            chk($sformatf("tbl_words[%0d]", r), ws[0], tv[r].w);
            step();
        end

        // back-to-back frames with no gap
        do_reset();
        pat = 8'hA5;
        iv[1] = 1; d[1] = 4'hA; sr[1] = 1;
        @(negedge clk);
        chk("b2b_accept_ready", ir[1], 1);
        step();
        d[1] = 4'h5;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) iv[1] = 0;
            @(negedge clk);
            chk($sformatf("b2b_bit[%0d]", k), so[1], pat[7-k]);
            chk($sformatf("b2b_busy[%0d]", k), {sv[1], by[1]}, 2'b11);
            chk($sformatf("b2b_ready[%0d]", k), ir[1], (k == 3 || k == 7) ? 1 : 0);
            step();
        end
        @(negedge clk);
        chk("b2b_idle", by[1], 0);
        chk("b2b_words", ws[1], 2);

        // lsb first and a two-cycle gap
        do_reset();
        iv[2] = 1; d[2] = 4'b0001; sr[2] = 1;
        step();
        iv[2] = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("lsb_bit[%0d]", k), so[2], k == 0 ? 1 : 0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("gap2_cycle[%0d]", k), {ir[2], by[2], sv[2]}, 3'b010);
            step();
        end
        @(negedge clk);
        chk("gap2_idle", {ir[2], by[2]}, 2'b10);

        // words_sent wrap
        do_reset();
        iv[1] = 1; sr[1] = 1; d[1] = 4'h3;
        step();
        for (int f = 1; f <= 256; f++) begin
            repeat (3) step();
            @(negedge clk);
            chk("wrap_frame_end", fe[1], 1);
            step();
            @(negedge clk);
            chk($sformatf("wrap_words[%0d]", f), ws[1], f % 256);
        end

        // randomized traffic against the scoreboard
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i] = $urandom_range(0, 3) != 0;
                d[i]  = 4'($urandom);
                sr[i] = $urandom_range(0, 3) != 0;
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e_sv = left[i] > 0;
                e_ir = (left[i] == 0 && gap[i] == 0) || (gapof(i) == 0 && left[i] == 1 && sr[i]);
                e = {e_sv, e_sv & pend[i][0], e_sv && left[i] == 4, e_sv && left[i] == 1, e_ir, !e_sv, e_sv || gap[i] > 0};
                chk($sformatf("rnd_status[%0d]@%0d", i, c), st(i), e);
                chk($sformatf("rnd_words[%0d]@%0d", i, c), ws[i], wcnt[i]);
                if (gap[i] > 0) gap[i]--;
                if (e_sv && sr[i]) begin
                    pend[i] = pend[i] >> 1;
                    left[i]--;
                    if (left[i] == 0) begin
                        wcnt[i] = wcnt[i] + 8'd1;
                        gap[i] = gapof(i);
                    end
                end
                if (iv[i] && e_ir) begin
                    pend[i] = order(i, d[i]);
                    left[i] = 4;
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
